// File: rtl/muldiv_if.sv
// Handshake and result bus between the control unit and muldiv_unit.
// The control unit drives the master side; muldiv_unit is the slave.
interface muldiv_if #(
    parameter int BUS_W = 32
);
    logic             start;
    logic [1:0]       op;
    logic [BUS_W-1:0] rs_data;
    logic [BUS_W-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [BUS_W-1:0] hi;
    logic [BUS_W-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one shift-add or restoring step per cycle.
// Defining MULDIV_DIV_EN compiles in the divide datapath; without it DIV/DIVU complete with zeros.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on acceptance
// RUN    | BUS_W iterations, counter counts down to terminal 0
// DONE   | sign fix-up, HI/LO write, done pulse
module muldiv_unit #(
    parameter int BUS_W = 32
) (
    input  logic    reloj_cucu,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(BUS_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    // Multiply: running product. Divide: {partial remainder, dividend/quotient}.
    logic [2*BUS_W-1:0] acc_q, acc_d;
    logic [2*BUS_W-1:0] mcand_q, mcand_d;
    // Multiply: multiplier shifted right. Divide: divisor.
    logic [BUS_W-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               flag_q, flag_d;
    logic [BUS_W-1:0]   hi_q, hi_d;
    logic [BUS_W-1:0]   lo_q, lo_d;
`ifdef MULDIV_DIV_EN
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [BUS_W:0]     diff;
`endif

    logic               sgn_op;
    logic [BUS_W-1:0]   abs_a, abs_b;
    logic [2*BUS_W-1:0] prod_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        flag_d   = flag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        diff      = acc_q[2*BUS_W-1:BUS_W-1] - {1'b0, opb_q};
`endif
        sgn_op   = ~bus.op[0];
        abs_a    = (sgn_op && bus.rs_data[BUS_W-1]) ? -bus.rs_data : bus.rs_data;
        abs_b    = (sgn_op && bus.rt_data[BUS_W-1]) ? -bus.rt_data : bus.rt_data;
        prod_fix = neg_q ? -acc_q : acc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    flag_d = 1'b0;
                    busy_d = 1'b1;
                    cnt_d  = CW'(BUS_W);
                    neg_d  = sgn_op && (bus.rs_data[BUS_W-1] ^ bus.rt_data[BUS_W-1]);
                    if (!bus.op[1]) begin
                        acc_d   = '0;
                        mcand_d = {{BUS_W{1'b0}}, abs_a};
                        opb_d   = abs_b;
                        state_d = S_RUN;
                    end else begin
`ifdef MULDIV_DIV_EN
                        neg_rem_d = sgn_op && bus.rs_data[BUS_W-1];
                        if (bus.rt_data == '0) begin
                            // Result is preloaded raw so DONE just copies it out.
                            dz_d      = 1'b1;
                            neg_d     = 1'b0;
                            neg_rem_d = 1'b0;
                            acc_d     = {bus.rs_data, {BUS_W{1'b1}}};
                            state_d   = S_DONE;
                        end else begin
                            dz_d    = 1'b0;
                            acc_d   = {{BUS_W{1'b0}}, abs_a};
                            opb_d   = abs_b;
                            state_d = S_RUN;
                        end
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (!op_q[1]) begin
                    if (opb_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d = mcand_q << 1;
                    opb_d   = opb_q >> 1;
                end
`ifdef MULDIV_DIV_EN
                else if (!diff[BUS_W]) begin
                    acc_d = {diff[BUS_W-1:0], acc_q[BUS_W-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*BUS_W-2:0], 1'b0};
                end
`endif
                if (cnt_d == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*BUS_W-1:BUS_W];
                    lo_d = prod_fix[BUS_W-1:0];
                end else begin
`ifdef MULDIV_DIV_EN
                    lo_d   = neg_q ? -acc_q[BUS_W-1:0] : acc_q[BUS_W-1:0];
                    hi_d   = neg_rem_q ? -acc_q[2*BUS_W-1:BUS_W] : acc_q[2*BUS_W-1:BUS_W];
                    flag_d = dz_q;
`else
                    hi_d = '0;
                    lo_d = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge reloj_cucu or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flag_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            flag_q    <= flag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = flag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus random operands against a plain-arithmetic model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    muldiv_if #(.BUS_W(W)) bus();
    muldiv_unit #(.BUS_W(W)) dut (.reloj_cucu(clk), .reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: full-width arithmetic on the operands, SV truncating division.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el,
                         output logic edz, output int elat);
        logic [2*W-1:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        edz = 1'b0;
        elat = W + 1;
        eh = '0;
        el = '0;
        case (op)
            2'b00: begin p = sa * sb; eh = p[2*W-1:W]; el = p[W-1:0]; end
            2'b01: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; eh = p[2*W-1:W]; el = p[W-1:0]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == '0) begin
                    eh = a; el = '1; edz = 1'b1; elat = 1;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    el = q[W-1:0]; eh = r[W-1:0];
                end else begin
                    el = a / b; eh = a % b;
                end
`else
                elat = 1;
`endif
            end
        endcase
    endtask

    // Issues one op and returns what the DUT produced; reissue_at>0 re-pulses start in that cycle.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int reissue_at,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic dz,
                         output int lat, output logic busy_ok);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        @(posedge clk); #1;
        busy_ok = bus.busy;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.start = (lat + 1 == reissue_at);
            bus.op = 2'($urandom);
            bus.rs_data = $urandom;
            bus.rt_data = $urandom;
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
        if (!bus.done) lat = -1;
        @(negedge clk);
        bus.start = 1'b0;
        h = bus.hi; l = bus.lo; dz = bus.div_by_zero;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = '0; bus.rs_data = '0; bus.rt_data = '0;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo, bus.div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_in: busy=%b done=%b hi=%h lo=%h dz=%b, required all zero",
                     bus.busy, bus.done, bus.hi, bus.lo, bus.div_by_zero);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo, bus.div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: busy=%b done=%b hi=%h lo=%h dz=%b, required all zero",
                     bus.busy, bus.done, bus.hi, bus.lo, bus.div_by_zero);
        end
    endtask

    // Runs one op against the model and checks result, latency, busy, and single-cycle done.
    task automatic test_one(input string name, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        logic [W-1:0] h, l, eh, el;
        logic dz, edz, bok;
        int lat, elat;
        model(op, a, b, eh, el, edz, elat);
        do_op(op, a, b, 0, h, l, dz, lat, bok);
        n_checks++;
        if ({h, l, dz} !== {eh, el, edz}) begin
            n_fail++;
            $display("FAIL %s result op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                     name, op, a, b, h, l, dz, eh, el, edz);
        end
        n_checks++;
        if (lat !== elat || bok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timing op=%0d: got latency=%0d busy_ok=%b, required latency=%0d busy_ok=1",
                     name, op, lat, bok, elat);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b, required 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_plan_mul();
        test_one("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_one("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        test_one("mult_minint", 2'b00, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_random_mul();
        for (int i = 0; i < 12; i++)
            test_one("rand_mul", 2'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div();
        logic [W-1:0] h, l;
        logic dz, bok;
        int lat;
        test_one("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        test_one("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        test_one("divu_zero", 2'b11, 32'h1234_5678, 32'h0);
        do_op(2'b01, 32'd3, 32'd5, 0, h, l, dz, lat, bok);
        n_checks++;
        if ({dz, l} !== {1'b0, 32'd15}) begin
            n_fail++;
            $display("FAIL dz_clear: got dz=%b lo=%h, required dz=0 lo=0000000f", dz, l);
        end
        for (int i = 0; i < 14; i++) begin
            logic [W-1:0] b;
            b = (i % 5 == 4) ? '0 : ((i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom));
            test_one("rand_div", 2'($urandom_range(2, 3)), $urandom, b);
        end
    endtask
`else
    task automatic test_div_disabled();
        test_one("divu_off", 2'b11, 32'd100, 32'd5);
        test_one("div_off_zero", 2'b10, 32'h1234_5678, 32'd0);
        test_one("multu_off", 2'b01, 32'd6, 32'd7);
    endtask
`endif

    task automatic test_busy_ignore();
        logic [W-1:0] h, l;
        logic dz, bok;
        int lat;
        do_op(2'b01, 32'd6, 32'd7, 10, h, l, dz, lat, bok);
        n_checks++;
        if ({h, l, lat} !== {32'd0, 32'd42, W + 1}) begin
            n_fail++;
            $display("FAIL busy_ignore: got hi=%h lo=%h latency=%0d, required hi=0 lo=2a latency=%0d",
                     h, l, lat, W + 1);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) break;
        end
        n_checks++;
        if ({bus.done, bus.busy, bus.lo} !== {2'b00, 32'd42}) begin
            n_fail++;
            $display("FAIL no_queue: got done=%b busy=%b lo=%h, required done=0 busy=0 lo=2a",
                     bus.done, bus.busy, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] h, l, eh, el;
        logic dz, edz, bok;
        int lat, elat;
        logic [W-1:0] a, b;
        for (int k = 0; k < 3; k++) begin
            a = $urandom; b = $urandom;
            model(2'b00, a, b, eh, el, edz, elat);
            do_op(2'b00, a, b, 0, h, l, dz, lat, bok);
            n_checks++;
            if ({h, l, lat} !== {eh, el, elat}) begin
                n_fail++;
                $display("FAIL back_to_back %0d: got hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=%0d",
                         k, h, l, lat, eh, el, elat);
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.rs_data = $urandom; bus.rt_data = $urandom;
        end
        n_checks++;
        if ({bus.hi, bus.lo} !== {eh, el}) begin
            n_fail++;
            $display("FAIL hold: got hi=%h lo=%h, required hi=%h lo=%h", bus.hi, bus.lo, eh, el);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd1234; bus.rt_data = 32'd99;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h, required all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk); rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got done/busy activity=%b after reset, required 0", seen_done);
        end
        test_one("after_reset", 2'b01, 32'd6, 32'd7);
    endtask

    initial begin
        test_reset();
        test_plan_mul();
        test_random_mul();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
